// File: rtl/adder3_pattern_checker.sv
// Stimulus-and-check engine for a 3-input 1-bit adder: walks {a,b,c} through 000..111 and scores out_in.
// Optional macro ADDER3_LOOP_EN: keep looping over the 8 patterns while start stays high.
module adder3_pattern_checker #(
   parameter int unsigned HOLD_CYCLES = 10,
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned ERR_W       = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             start,
   input  logic [1:0]       out_in,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic [2:0]       pat_idx,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       first_fail,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] LAT       = 8'(LATENCY);

   state_t           state_q;
   logic [7:0]       hold_cnt_q;
   logic [2:0]       pat_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic [3:0]       first_fail_q;

   logic [1:0]       exp_sum;
   logic             cmp_en;
   logic             mismatch;
   logic [ERR_W-1:0] err_cnt_d;
   logic [3:0]       first_fail_d;
   logic             last_hold;

   // Expected sum is formed from the registered pattern that is currently on a/b/c.
   always_comb begin
      exp_sum      = {1'b0, pat_q[2]} + {1'b0, pat_q[1]} + {1'b0, pat_q[0]};
      cmp_en       = (state_q == ST_RUN) && (hold_cnt_q >= LAT);
      mismatch     = cmp_en && (out_in != exp_sum);
      err_cnt_d    = err_cnt_q;
      first_fail_d = first_fail_q;
      if (mismatch) begin
         if (err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
         if (!first_fail_q[3]) begin
            first_fail_d = {1'b1, pat_q};
         end
      end
      last_hold = (hold_cnt_q == HOLD_LAST);
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q      <= ST_IDLE;
         hold_cnt_q   <= 8'd0;
         pat_q        <= 3'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_cnt_q    <= '0;
         first_fail_q <= 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q      <= ST_RUN;
                  hold_cnt_q   <= 8'd0;
                  pat_q        <= 3'd0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  err_cnt_q    <= '0;
                  first_fail_q <= 4'd0;
               end
            end
            ST_RUN: begin
               err_cnt_q    <= err_cnt_d;
               first_fail_q <= first_fail_d;
               done_q       <= 1'b0;
               if (last_hold) begin
                  hold_cnt_q <= 8'd0;
                  if (pat_q != 3'd7) begin
                     pat_q <= pat_q + 3'd1;
                  end else begin
`ifdef ADDER3_LOOP_EN
                     // Pass verdict uses err_cnt_d so the final compare cycle is included.
                     if (start) begin
                        pat_q  <= 3'd0;
                        done_q <= 1'b1;
                        pass_q <= (err_cnt_d == '0);
                     end else begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                     end
`else
                     // Pass verdict uses err_cnt_d so the final compare cycle is included.
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_cnt_d == '0);
`endif
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
            end
            ST_DONE: begin
               if (!start) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign a           = pat_q[2];
   assign b           = pat_q[1];
   assign c           = pat_q[0];
   assign pat_idx     = pat_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign err_cnt     = err_cnt_q;
   assign first_fail  = first_fail_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adder3_pattern_checker.sv
// Directed bench for adder3_pattern_checker: a modelled registered adder feeds out_in in several fault modes,
// and a second instance with a 4-bit error counter sees a stuck-at-0 adder.
module tb_adder3_pattern_checker;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       start = 1'b0;
   logic [1:0] out_in;
   logic       a, b, c;
   logic [2:0] pat_idx;
   logic       busy, done, pass;
   logic [7:0] err_cnt;
   logic [3:0] first_fail;
   logic [1:0] dbg_state;

   logic       a2, b2, c2;
   logic [2:0] pat_idx2;
   logic       busy2, done2, pass2;
   logic [3:0] err_cnt2;
   logic [3:0] first_fail2;
   logic [1:0] dbg_state2;

   int n_tests = 0;
   int n_fail  = 0;
   int mode    = 3;   // 0: delay 2, 1: stuck 00, 2: delay 3, other: constant 11

   logic [2:0] exp_q[$];
   logic [1:0] p1 = 2'd0, p2 = 2'd0, p3 = 2'd0;

   adder3_pattern_checker #(.HOLD_CYCLES(10), .LATENCY(2), .ERR_W(8)) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .out_in(out_in),
      .a(a), .b(b), .c(c), .pat_idx(pat_idx), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .first_fail(first_fail), .dbg_state_o(dbg_state)
   );

   adder3_pattern_checker #(.HOLD_CYCLES(10), .LATENCY(2), .ERR_W(4)) dut_sat (
      .Clk(Clk), .Rst(Rst), .start(start), .out_in(2'b00),
      .a(a2), .b(b2), .c(c2), .pat_idx(pat_idx2), .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err_cnt2), .first_fail(first_fail2), .dbg_state_o(dbg_state2)
   );

   // clock and adder model
   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      p1 <= {1'b0, a} + {1'b0, b} + {1'b0, c};
      p2 <= p1;
      p3 <= p2;
   end

   always_comb begin
      case (mode)
         0:       out_in = p2;
         1:       out_in = 2'b00;
         2:       out_in = p3;
         default: out_in = 2'b11;
      endcase
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " abc"}, {29'd0, a, b, c}, 0);
      check({tag, " pat_idx"}, pat_idx, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " pass"}, pass, 0);
      check({tag, " err_cnt"}, err_cnt, 0);
      check({tag, " first_fail"}, first_fail, 0);
      check({tag, " state"}, dbg_state, ST_IDLE);
      check({tag, " sat err_cnt"}, err_cnt2, 0);
   endtask

   // Launch one run, track the a/b/c staircase, then check the verdict in DONE.
   task automatic run_one(input string tag, input int exp_err, input logic exp_pass,
                          input logic [3:0] exp_ff);
      int  k;
      bit  seen;
      logic [2:0] e;
      exp_q.delete();
      for (int p = 0; p < 8; p++) exp_q.push_back(3'(p));
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      k    = 0;
      seen = 0;
      for (int n = 0; n < 200 && !seen; n++) begin
         if (done) begin
            seen = 1;
         end else begin
            if (k % 10 == 5 && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check({tag, " abc"}, {29'd0, a, b, c}, {29'd0, e});
               check({tag, " pat_idx"}, pat_idx, e);
               check({tag, " busy"}, busy, 1);
            end
            k++;
            @(negedge Clk);
         end
      end
      check({tag, " done seen"}, seen, 1);
      check({tag, " run cycles"}, k, 80);
      check({tag, " patterns left"}, exp_q.size(), 0);
      check({tag, " state"}, dbg_state, ST_DONE);
      check({tag, " busy end"}, busy, 0);
      check({tag, " err_cnt"}, err_cnt, exp_err);
      check({tag, " pass"}, pass, exp_pass);
      check({tag, " first_fail"}, first_fail, exp_ff);
      check({tag, " abc hold"}, {29'd0, a, b, c}, 7);
   endtask

   // start high in DONE must not rerun; dropping it returns to IDLE with results kept.
   task automatic leave_done(input string tag, input int exp_err);
      start = 1'b1;
      repeat (3) @(negedge Clk);
      check({tag, " done held"}, done, 1);
      check({tag, " state held"}, dbg_state, ST_DONE);
      start = 1'b0;
      @(negedge Clk);
      check({tag, " done cleared"}, done, 0);
      check({tag, " idle"}, dbg_state, ST_IDLE);
      check({tag, " err kept"}, err_cnt, exp_err);
   endtask

   initial begin
      int n;
      // reset held with start high and out_in = 3
      Rst   = 1'b0;
      start = 1'b1;
      mode  = 3;
      repeat (10) @(negedge Clk);
      check_zero("reset");

      Rst = 1'b1;
      @(negedge Clk);
      check("release busy", busy, 1);
      check("release state", dbg_state, ST_RUN);
      check("release pat", pat_idx, 0);
      start = 1'b0;

      // abort mid-run at pattern 4
      n = 0;
      while (pat_idx != 3'd4 && n < 100) begin
         @(negedge Clk);
         n++;
      end
      check("abort reached pat4", pat_idx, 4);
      Rst = 1'b0;
      @(negedge Clk);
      check_zero("abort");
      Rst = 1'b1;
      @(negedge Clk);

      // good adder, 2-cycle latency; saturating instance sees stuck-at-0
      mode = 0;
      run_one("good", 0, 1'b1, 4'b0000);
      check("sat err_cnt", err_cnt2, 15);
      check("sat pass", pass2, 0);
      check("sat first_fail", first_fail2, 4'b1001);
      leave_done("good", 0);

      // stuck-at-00: patterns 001..111 each miss 8 compares -> 56, first miss on 001
      mode = 1;
      run_one("stuck", 56, 1'b0, 4'b1001);
      leave_done("stuck", 56);

      // delay 3: one miss where the sum differs from the previous cycle's pattern.
      // Sums 3(idle 111)->0,1,1,2,1,2,2,3: changes at 000,001,011,100,101,111 -> 6, first on 000
      mode = 2;
      run_one("late", 6, 1'b0, 4'b1000);
      leave_done("late", 6);

`ifdef ADDER3_LOOP_EN
      begin
         int  gap;
         bit  seen;
         mode  = 0;
         start = 1'b1;
         seen  = 0;
         for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge Clk);
            if (done) seen = 1;
         end
         check("loop pulse1", seen, 1);
         @(negedge Clk);
         check("loop pulse width", done, 0);
         check("loop busy", busy, 1);
         check("loop wrap pat", pat_idx, 0);
         gap  = 1;
         seen = 0;
         for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge Clk);
            gap++;
            if (done) seen = 1;
         end
         check("loop pulse2", seen, 1);
         check("loop gap", gap, 80);
         check("loop pass", pass, 1);
         repeat (5) @(negedge Clk);
         start = 1'b0;
         seen  = 0;
         for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge Clk);
            if (done) seen = 1;
         end
         check("loop final done", seen, 1);
         check("loop final state", dbg_state, ST_DONE);
         check("loop final busy", busy, 0);
         check("loop final err", err_cnt, 0);
         @(negedge Clk);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
